// File: rtl/uart_hex_cmd_rx.sv
// uart_hex_cmd_rx
//   Parses ASCII hex numbers arriving byte-by-byte from a uart_rx instance.
//   A number is a run of hex digits ('0'-'9', 'A'-'F', 'a'-'f') closed by
//   CR_CHAR or LF_CHAR. A well-formed number updates value/digit_count and
//   pulses value_valid; a malformed or over-long number pulses err instead.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rx_data[7:0]    byte from uart_rx
//   rx_ready        uart_rx has a byte available
//   rx_ready_rst    clears the uart_rx ready flag; held until rx_ready drops
//   value           last successfully parsed number (4*DIGITS bits)
//   value_valid     one-cycle pulse when value updates
//   digit_count     digit count of the last valid number
//   err             one-cycle pulse when a malformed number is dropped
//   tx_start, tx_data, tx_busy   echo port to uart_tx (ECHO_EN only)
//
// Build option:
//   ECHO_EN  define to echo every consumed byte through the tx port.
module uart_hex_cmd_rx #(
  parameter int         DIGITS  = 8,
  parameter logic [7:0] CR_CHAR = 8'h0d,
  parameter logic [7:0] LF_CHAR = 8'h0a
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_ready,
  output logic                         rx_ready_rst,
  output logic [4*DIGITS-1:0]          value,
  output logic                         value_valid,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         err
`ifdef ECHO_EN
  ,
  output logic                         tx_start,
  output logic [7:0]                   tx_data,
  input  logic                         tx_busy
`endif
);

  localparam int VW = 4*DIGITS;
  localparam int CW = $clog2(DIGITS+1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DISCARD, S_CLR} state_t;

  // ---------------------------------------------------------------------
  // Byte classification
  // ---------------------------------------------------------------------
  logic       is_term, is_dig;
  logic [3:0] dig;

  always_comb begin
    is_term = (rx_data == CR_CHAR) || (rx_data == LF_CHAR);
    is_dig  = 1'b0;
    dig     = 4'h0;
    // Terminators win if a terminator parameter collides with a digit code.
    if (!is_term) begin
      if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
        is_dig = 1'b1;
        dig    = rx_data[3:0];
      end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                   (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
        // Low nibble of 'A'/'a' is 1, so +9 yields 10..15.
        is_dig = 1'b1;
        dig    = rx_data[3:0] + 4'd9;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Parser FSM
  // ---------------------------------------------------------------------
  state_t          state_q, state_d;
  state_t          ret_q, ret_d;      // state to resume after CLR
  logic [VW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   value_q, value_d;
  logic [CW-1:0]   dcnt_q, dcnt_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            rrst_q, rrst_d;
  logic            consume;

  // A byte is taken whenever we are not still waiting for the previous
  // ready flag to clear; CLR blocks re-consuming the same byte.
  assign consume = (state_q != S_CLR) && rx_ready;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    dcnt_d  = dcnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rrst_d  = rrst_q;

    if (state_q == S_CLR) begin
      if (!rx_ready) begin
        rrst_d  = 1'b0;
        state_d = ret_q;
      end
    end else if (consume) begin
      rrst_d  = 1'b1;
      state_d = S_CLR;
      ret_d   = state_q;
      case (state_q)
        S_IDLE: begin
          if (is_dig) begin
            acc_d = VW'(dig);       // clears any stale upper digits
            cnt_d = CW'(1);
            ret_d = S_ACCUM;
          end else if (!is_term) begin
            ret_d = S_DISCARD;
          end
          // bare terminator (e.g. LF after CR) is ignored
        end
        S_ACCUM: begin
          if (is_dig) begin
            if (cnt_q < CW'(DIGITS)) begin
              acc_d = (acc_q << 4) | VW'(dig);
              cnt_d = cnt_q + CW'(1);
            end else begin
              ret_d = S_DISCARD;    // too many digits
            end
          end else if (is_term) begin
            value_d = acc_q;
            dcnt_d  = cnt_q;
            valid_d = 1'b1;
            ret_d   = S_IDLE;
          end else begin
            ret_d = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (is_term) begin
            err_d = 1'b1;
            ret_d = S_IDLE;
          end
        end
        default: ret_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      dcnt_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rrst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      dcnt_q  <= dcnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rrst_q  <= rrst_d;
    end
  end

  assign rx_ready_rst = rrst_q;
  assign value        = value_q;
  assign value_valid  = valid_q;
  assign digit_count  = dcnt_q;
  assign err          = err_q;

`ifdef ECHO_EN
  // ---------------------------------------------------------------------
  // Echo: one byte in flight at a time; bytes consumed while an echo is
  // still pending are not echoed.
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {E_IDLE, E_START, E_WAIT} echo_t;

  echo_t      echo_q, echo_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_comb begin
    echo_d     = echo_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    case (echo_q)
      E_IDLE: begin
        if (consume) begin
          tx_data_d  = rx_data;
          tx_start_d = 1'b1;
          echo_d     = E_START;
        end
      end
      E_START: begin
        // uart_tx has latched the byte once it reports busy
        if (tx_busy) begin
          tx_start_d = 1'b0;
          echo_d     = E_WAIT;
        end
      end
      E_WAIT: begin
        if (!tx_busy) echo_d = E_IDLE;
      end
      default: echo_d = E_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_q     <= E_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      echo_q     <= echo_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
`endif

endmodule

// File: tb/tb_uart_hex_cmd_rx.sv
`timescale 1ns/1ps
module tb_uart_hex_cmd_rx;
  localparam int DIGITS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        rx_ready_rst;
  logic [31:0] value;
  logic        value_valid;
  logic [3:0]  digit_count;
  logic        err;
`ifdef ECHO_EN
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
`endif

  uart_hex_cmd_rx #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_ready_rst(rx_ready_rst), .value(value), .value_valid(value_valid),
    .digit_count(digit_count), .err(err)
`ifdef ECHO_EN
    , .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  typedef struct { bit is_err; logic [31:0] v; logic [3:0] c; } ev_t;
  ev_t  obs_q[$];
  int   consumes = 0;
  logic rrst_prev = 1'b0;

  always @(negedge clk) begin
    if (value_valid || err) chk("valid_err_exclusive", {63'd0, value_valid & err}, 64'd0);
    if (value_valid) obs_q.push_back('{1'b0, value, digit_count});
    if (err)         obs_q.push_back('{1'b1, 32'd0, 4'd0});
    if (rx_ready_rst && !rrst_prev) consumes++;
    rrst_prev = rx_ready_rst;
  end

`ifdef ECHO_EN
  // uart_tx model: busy for 10 cycles per accepted byte
  int         bcnt = 0;
  logic [7:0] txq[$];
  assign tx_busy = (bcnt != 0);
  always @(posedge clk) begin
    if (bcnt != 0) bcnt <= bcnt - 1;
    else if (tx_start) begin
      txq.push_back(tx_data);
      bcnt <= 10;
    end
  end
  always @(negedge clk) begin
    if (bcnt == 10) chk("tx_start_seen", {63'd0, tx_start}, 64'd1);
    if (bcnt == 9)  chk("tx_start_dropped", {63'd0, tx_start}, 64'd0);
  end
`endif

  // ---------------- uart_rx model ----------------
  // Presents a byte, keeps ready high 'hold' cycles after ready_rst is seen,
  // then waits for ready_rst to clear. Caller is always #1 after posedge.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    int t;
    rx_data = b;
    rx_ready = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!rx_ready_rst && t < 50);
    chk("consume_bound", {63'd0, rx_ready_rst}, 64'd1);
    repeat (hold) begin @(posedge clk); #1; end
    rx_ready = 1'b0;
    t = 0;
    while (rx_ready_rst && t < 50) begin @(posedge clk); #1; t++; end
    chk("ready_rst_release_bound", {63'd0, rx_ready_rst}, 64'd0);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_str(input string s, input int hold);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], hold, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  // ---------------- reference model (token level) ----------------
  int          tok_len = 0;
  bit          tok_bad = 1'b0;
  logic [31:0] tok_val = 0;
  logic [31:0] mval = 0;
  logic [3:0]  mcnt = 0;
  ev_t         exp_q[$];

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int d;
    if (b == 8'h0d || b == 8'h0a) begin
      if (tok_len > 0) begin
        if (!tok_bad && tok_len <= DIGITS) begin
          mval = tok_val;
          mcnt = 4'(tok_len);
          exp_q.push_back('{1'b0, tok_val, 4'(tok_len)});
        end else begin
          exp_q.push_back('{1'b1, 32'd0, 4'd0});
        end
      end
      tok_len = 0; tok_bad = 1'b0; tok_val = 0;
    end else begin
      d = hexval(b);
      if (d < 0) tok_bad = 1'b1;
      else tok_val = tok_val * 16 + d;
      tok_len++;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct { string s; int nv; int ne; logic [31:0] val; logic [3:0] cnt; } vec_t;
  vec_t vt[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nv, ne, c0, len;
    logic [7:0] bad[4];
    logic [7:0] tok[$];
    logic [7:0] b;
    int r;

    vt[0] = '{"1A2b\r",       1, 0, 32'h00001A2B, 4'd4};
    vt[1] = '{"FFFFFFFF\r\n", 1, 0, 32'hFFFFFFFF, 4'd8};
    vt[2] = '{"123456789\r",  0, 1, 32'hFFFFFFFF, 4'd8};
    vt[3] = '{"12G4\n",       0, 1, 32'hFFFFFFFF, 4'd8};
    vt[4] = '{"7\n",          1, 0, 32'h00000007, 4'd1};
    vt[5] = '{"\r\n",         0, 0, 32'h00000007, 4'd1};
    vt[6] = '{"g0\r",         0, 1, 32'h00000007, 4'd1};
    vt[7] = '{"00c0ffee\n",   1, 0, 32'h00C0FFEE, 4'd8};
    bad[0] = 8'h47; bad[1] = 8'h7a; bad[2] = 8'h2e; bad[3] = 8'h20;

    // reset state
    repeat (3) begin @(posedge clk); #1; end
    chk("reset_value", {32'd0, value}, 64'd0);
    chk("reset_valid", {63'd0, value_valid}, 64'd0);
    chk("reset_err", {63'd0, err}, 64'd0);
    chk("reset_count", {60'd0, digit_count}, 64'd0);
    chk("reset_ready_rst", {63'd0, rx_ready_rst}, 64'd0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // table vectors
    for (int i = 0; i < 8; i++) begin
      obs_q.delete();
      c0 = consumes;
      send_str(vt[i].s, i % 3);
      repeat (3) begin @(posedge clk); #1; end
      nv = 0; ne = 0;
      foreach (obs_q[k]) if (obs_q[k].is_err) ne++; else nv++;
      chk($sformatf("vec%0d_nvalid", i), 64'(nv), 64'(vt[i].nv));
      chk($sformatf("vec%0d_nerr", i), 64'(ne), 64'(vt[i].ne));
      chk($sformatf("vec%0d_value", i), {32'd0, value}, {32'd0, vt[i].val});
      chk($sformatf("vec%0d_count", i), {60'd0, digit_count}, {60'd0, vt[i].cnt});
      chk($sformatf("vec%0d_consumes", i), 64'(consumes - c0), 64'(vt[i].s.len()));
    end

    // reset mid-number: partial "AB" is dropped silently
    obs_q.delete();
    c0 = consumes;
    send_str("AB", 2);
    do_reset(3);
    chk("midrst_value", {32'd0, value}, 64'd0);
    chk("midrst_count", {60'd0, digit_count}, 64'd0);
    send_str("C\r", 2);
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_events", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1) chk("midrst_ev_kind", {63'd0, obs_q[0].is_err}, 64'd0);
    chk("midrst_value_c", {32'd0, value}, 64'h0000000C);
    chk("midrst_count_c", {60'd0, digit_count}, 64'd1);
    chk("midrst_consumes", 64'(consumes - c0), 64'd4);

    // randomized tokens against the reference model
    do_reset(2);
    obs_q.delete(); exp_q.delete();
    mval = 0; mcnt = 0; tok_len = 0; tok_bad = 1'b0; tok_val = 0;
    for (int t = 0; t < 40; t++) begin
      tok.delete();
      len = $urandom_range(0, 10);
      for (int j = 0; j < len; j++) begin
        r = $urandom_range(0, 29);
        if (r == 0) b = bad[$urandom_range(0, 3)];
        else begin
          r = $urandom_range(0, 15);
          if (r < 10) b = 8'(8'h30 + r);
          else if ($urandom_range(0, 1) == 1) b = 8'(8'h41 + r - 10);
          else b = 8'(8'h61 + r - 10);
        end
        tok.push_back(b);
      end
      tok.push_back(($urandom_range(0, 1) == 1) ? 8'h0d : 8'h0a);
      if ($urandom_range(0, 3) == 0) tok.push_back(8'h0a);
      foreach (tok[j]) begin
        model_byte(tok[j]);
        send_byte(tok[j], $urandom_range(0, 3), $urandom_range(0, 2));
      end
      repeat (3) begin @(posedge clk); #1; end
      chk($sformatf("rnd%0d_nevents", t), 64'(obs_q.size()), 64'(exp_q.size()));
      if (obs_q.size() == exp_q.size()) begin
        foreach (exp_q[k]) begin
          chk($sformatf("rnd%0d_kind", t), {63'd0, obs_q[k].is_err}, {63'd0, exp_q[k].is_err});
          if (!exp_q[k].is_err) begin
            chk($sformatf("rnd%0d_evval", t), {32'd0, obs_q[k].v}, {32'd0, exp_q[k].v});
            chk($sformatf("rnd%0d_evcnt", t), {60'd0, obs_q[k].c}, {60'd0, exp_q[k].c});
          end
        end
      end
      chk($sformatf("rnd%0d_value", t), {32'd0, value}, {32'd0, mval});
      chk($sformatf("rnd%0d_count", t), {60'd0, digit_count}, {60'd0, mcnt});
      obs_q.delete(); exp_q.delete();
    end

`ifdef ECHO_EN
    // echo: bytes spaced so each echo completes before the next byte
    do_reset(2);
    repeat (15) begin @(posedge clk); #1; end
    txq.delete();
    send_byte(8'h35, 2, 15);
    send_byte(8'h0d, 2, 15);
    repeat (15) begin @(posedge clk); #1; end
    chk("echo_count", 64'(txq.size()), 64'd2);
    if (txq.size() == 2) begin
      chk("echo_byte0", {56'd0, txq[0]}, 64'h35);
      chk("echo_byte1", {56'd0, txq[1]}, 64'h0d);
    end
    chk("echo_value", {32'd0, value}, 64'h5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
